// File: rtl/tc_wb_pkg.sv
// Shared types and constants for the tensor-core writeback collector.
//   wb_state_e  : collector FSM state
//   FFLAGS_W    : width of an FP exception flag vector
//   REG_IDX_W   : width of a destination register index
package tc_wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } wb_state_e;

    localparam int unsigned FFLAGS_W  = 5;
    localparam int unsigned REG_IDX_W = 8;

endpackage

// File: rtl/tensor_core_params.svh
// Tensor-core wide parameters shared by the FP pipeline and its consumers.
//   DEPTH_WARP : width of a warp id
`ifndef TENSOR_CORE_PARAMS_SVH
`define TENSOR_CORE_PARAMS_SVH
`define DEPTH_WARP 3
`endif

// File: rtl/tc_add_wb_collect.sv
// Gathers consecutive same-tag scalar results from the FP add pipe into one
// lane-vector writeback packet and hands it to the register-file port.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o  : result handshake from the add pipe
//   in_result_i, in_fflags_i : FP result and its exception flags
//   in_reg_idxw_i, in_warpid_i : writeback tag of the result
//   out_valid_o / out_ready_i  : packet handshake to the writeback port
//   out_data_o               : lane i at bits [i*W +: W]
//   out_mask_o, out_fflags_o : lane-valid mask, OR of collected flags
//   out_reg_idxw_o, out_warpid_o : packet tag
`include "tensor_core_params.svh"

module tc_add_wb_collect
    import tc_wb_pkg::*;
#(
    parameter int unsigned EXPWIDTH  = 5,
    parameter int unsigned PRECISION = 11,
    parameter int unsigned LANES     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [EXPWIDTH+PRECISION-1:0]          in_result_i,
    input  logic [FFLAGS_W-1:0]                    in_fflags_i,
    input  logic [REG_IDX_W-1:0]                   in_reg_idxw_i,
    input  logic [`DEPTH_WARP-1:0]                 in_warpid_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [LANES*(EXPWIDTH+PRECISION)-1:0]  out_data_o,
    output logic [LANES-1:0]                       out_mask_o,
    output logic [FFLAGS_W-1:0]                    out_fflags_o,
    output logic [REG_IDX_W-1:0]                   out_reg_idxw_o,
    output logic [`DEPTH_WARP-1:0]                 out_warpid_o
);

    localparam int unsigned W     = EXPWIDTH + PRECISION;
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    wb_state_e                  state_r;
    wb_state_e                  state_nxt_s;
    logic [CNT_W-1:0]           cnt_r;
    logic [LANES*W-1:0]         data_r;
    logic [LANES-1:0]           mask_r;
    logic [FFLAGS_W-1:0]        fflags_r;
    logic [REG_IDX_W-1:0]       reg_idxw_r;
    logic [`DEPTH_WARP-1:0]     warpid_r;
    logic                       out_valid_r;

    logic                       tag_match_s;
    logic                       last_lane_s;
    logic                       accept_s;
    logic                       send_done_s;
    logic                       in_ready_s;

    assign tag_match_s = (in_reg_idxw_i == reg_idxw_r) && (in_warpid_i == warpid_r);
    assign last_lane_s = (cnt_r == CNT_W'(LANES - 1));
    assign accept_s    = in_valid_i && in_ready_s;
    assign send_done_s = out_valid_r && out_ready_i;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a valid result with a foreign tag flushes the partial packet.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (LANES == 1) ? SEND : COLLECT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                if (in_valid_i && !tag_match_s) begin
                    state_nxt_s = SEND;
                end else if (accept_s && last_lane_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            SEND: begin
                if (send_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Input ready: combinational on the current input tag, forced low during reset.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                COLLECT: in_ready_s = !in_valid_i || tag_match_s;
                SEND:    in_ready_s = 1'b0;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    // Packet valid flag, registered so out_valid_o has no path from the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == SEND);
        end
    end

    // Packet assembly: tag capture, indexed lane writes, flag accumulation, clear after send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= '0;
            data_r     <= '0;
            mask_r     <= '0;
            fflags_r   <= '0;
            reg_idxw_r <= '0;
            warpid_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        reg_idxw_r    <= in_reg_idxw_i;
                        warpid_r      <= in_warpid_i;
                        data_r[W-1:0] <= in_result_i;
                        mask_r        <= LANES'(1);
                        fflags_r      <= in_fflags_i;
                        cnt_r         <= CNT_W'(1);
                    end
                end
                COLLECT: begin
                    if (accept_s) begin
                        for (int i = 0; i < int'(LANES); i++) begin
                            if (cnt_r == CNT_W'(i)) begin
                                data_r[i*W +: W] <= in_result_i;
                                mask_r[i]        <= 1'b1;
                            end
                        end
                        fflags_r <= fflags_r | in_fflags_i;
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
                SEND: begin
                    // Clearing here keeps unfilled lanes of the next partial packet at zero.
                    if (send_done_s) begin
                        cnt_r    <= '0;
                        data_r   <= '0;
                        mask_r   <= '0;
                        fflags_r <= '0;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready_o     = in_ready_s;
    assign out_valid_o    = out_valid_r;
    assign out_data_o     = data_r;
    assign out_mask_o     = mask_r;
    assign out_fflags_o   = fflags_r;
    assign out_reg_idxw_o = reg_idxw_r;
    assign out_warpid_o   = warpid_r;

endmodule
